// File: rtl/overlay_pkg.sv
// Shared types and default frame constants for the text overlay sequencer.
package overlay_pkg;

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_PAUSE  = 2'd1,
    ST_RESULT = 2'd2
  } overlay_state_t;

  localparam int unsigned DEF_BLINK_FRAMES  = 30;
  localparam int unsigned DEF_RESULT_FRAMES = 300;
  localparam int unsigned DEF_NOTIFY_FRAMES = 180;

endpackage

// File: rtl/overlay_sequencer_frame_tick.sv
// Registered vsync rising-edge detector: one-cycle frame tick per vsync pulse.
module frame_tick (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vsync,
  output logic o_tick
);

  logic r_vsync_d;
  logic r_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vsync_d <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_vsync_d <= i_vsync;
      r_tick    <= i_vsync & ~r_vsync_d;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/overlay_sequencer.sv
// Frame-level controller choosing which overlay messages are enabled each frame.
module overlay_sequencer
  import overlay_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES  = DEF_BLINK_FRAMES,
  parameter int unsigned RESULT_FRAMES = DEF_RESULT_FRAMES,
  parameter int unsigned NOTIFY_FRAMES = DEF_NOTIFY_FRAMES
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic pause,
  input  logic p2_connected,
  input  logic game_over,
  input  logic looser,
  output logic show_help,
  output logic show_pause,
  output logic show_result,
  output logic result_looser,
  output logic show_p2_status,
  output logic show_sw15_hint
);

  localparam int unsigned RES_W = $clog2(RESULT_FRAMES + 1);
  localparam int unsigned BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned NTF_W = $clog2(NOTIFY_FRAMES + 1);

  localparam logic [RES_W-1:0] RES_INIT   = RES_W'(RESULT_FRAMES - 1);
  localparam logic [RES_W-1:0] RES_ONE    = RES_W'(1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [BLK_W-1:0] BLK_ONE    = BLK_W'(1);
  localparam logic [NTF_W-1:0] NTF_INIT   = NTF_W'(NOTIFY_FRAMES);
  localparam logic [NTF_W-1:0] NTF_ONE    = NTF_W'(1);

  logic           w_tick;
  logic           w_go_rise;
  logic           w_p2_edge;
  overlay_state_t r_state;
  overlay_state_t w_state_nxt;

  logic             r_go_d;
  logic             r_p2_d;
  logic [RES_W-1:0] r_res_cnt;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_phase;
  logic [NTF_W-1:0] r_ntf_cnt;
  logic             r_looser;

  logic r_show_help;
  logic r_show_pause;
  logic r_show_result;
  logic r_result_looser;
  logic r_show_p2_status;
  logic r_show_sw15_hint;

  frame_tick u_frame_tick (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_vsync (vsync),
    .o_tick  (w_tick)
  );

  assign w_go_rise = game_over & ~r_go_d;
  assign w_p2_edge = p2_connected ^ r_p2_d;

  // go_rise is applied last so it overrides both pause changes and expiry.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_PLAY:   if (pause)  w_state_nxt = ST_PAUSE;
      ST_PAUSE:  if (!pause) w_state_nxt = ST_PLAY;
      ST_RESULT: begin
        if (w_tick && (r_res_cnt == '0))
          w_state_nxt = pause ? ST_PAUSE : ST_PLAY;
      end
      default:   w_state_nxt = ST_PLAY;
    endcase
    if (w_go_rise) w_state_nxt = ST_RESULT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_PLAY;
      r_go_d      <= 1'b0;
      r_p2_d      <= 1'b0;
      r_res_cnt   <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_ntf_cnt   <= '0;
      r_looser    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_go_d  <= game_over;
      r_p2_d  <= p2_connected;

      if (w_go_rise) begin
        r_looser    <= looser;
        r_res_cnt   <= RES_INIT;
        r_blink_cnt <= '0;
        r_phase     <= 1'b1;
      end else if ((r_state == ST_RESULT) && w_tick) begin
        if (r_res_cnt != '0) r_res_cnt <= r_res_cnt - RES_ONE;
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BLK_ONE;
        end
      end

      if (w_p2_edge)
        r_ntf_cnt <= NTF_INIT;
      else if (w_tick && (r_ntf_cnt != '0))
        r_ntf_cnt <= r_ntf_cnt - NTF_ONE;
    end
  end

  // The p2_edge term lets the notice appear on the same cycle the counter loads,
  // so a link present at reset release is shown on the first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_show_help      <= 1'b0;
      r_show_pause     <= 1'b0;
      r_show_result    <= 1'b0;
      r_result_looser  <= 1'b0;
      r_show_p2_status <= 1'b0;
      r_show_sw15_hint <= 1'b0;
    end else begin
      r_show_help      <= (r_state == ST_PAUSE);
      r_show_pause     <= (r_state == ST_PAUSE);
      r_show_result    <= (r_state == ST_RESULT) & r_phase;
      r_result_looser  <= r_looser;
      r_show_p2_status <= (r_state == ST_PAUSE) |
                          ((r_state == ST_PLAY) & ((r_ntf_cnt != '0) | w_p2_edge));
      r_show_sw15_hint <= (r_state == ST_PLAY);
    end
  end

  assign show_help      = r_show_help;
  assign show_pause     = r_show_pause;
  assign show_result    = r_show_result;
  assign result_looser  = r_result_looser;
  assign show_p2_status = r_show_p2_status;
  assign show_sw15_hint = r_show_sw15_hint;

endmodule

// File: tb/tb_overlay_sequencer.sv
// Directed bench for overlay_sequencer with a queue of expected output vectors.
module tb_overlay_sequencer;

  logic clk;
  logic rst;
  logic vsync;
  logic pause;
  logic p2_connected;
  logic game_over;
  logic looser;
  logic show_help;
  logic show_pause;
  logic show_result;
  logic result_looser;
  logic show_p2_status;
  logic show_sw15_hint;

  typedef struct {
    string      tag;
    logic [5:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;

  // {help, pause, result, looser, p2_status, sw15}
  logic [5:0] obs;
  assign obs = {show_help, show_pause, show_result, result_looser,
                show_p2_status, show_sw15_hint};

  overlay_sequencer #(
    .BLINK_FRAMES  (2),
    .RESULT_FRAMES (6),
    .NOTIFY_FRAMES (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .vsync          (vsync),
    .pause          (pause),
    .p2_connected   (p2_connected),
    .game_over      (game_over),
    .looser         (looser),
    .show_help      (show_help),
    .show_pause     (show_pause),
    .show_result    (show_result),
    .result_looser  (result_looser),
    .show_p2_status (show_p2_status),
    .show_sw15_hint (show_sw15_hint)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [5:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
      end
    end
  endtask

  // One 20-clock frame: vsync high for 2 clocks, then low.
  task automatic frame();
    vsync = 1'b1;
    step(2);
    vsync = 1'b0;
    step(18);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    vsync        = 1'b0;
    pause        = 1'b0;
    p2_connected = 1'b0;
    game_over    = 1'b0;
    looser       = 1'b0;

    // Reset
    expect_out("reset_hold", 6'b000000);
    step(3);
    check_out();
    rst = 1'b0;
    expect_out("reset_release", 6'b000001);
    step(1);
    check_out();

    // Pause toggle
    pause = 1'b1;
    expect_out("pause_lat1", 6'b000001);
    step(1);
    check_out();
    expect_out("pause_on", 6'b110010);
    step(1);
    check_out();
    pause = 1'b0;
    expect_out("pause_off", 6'b000001);
    step(2);
    check_out();

    // P2 notice: 3 ticks
    p2_connected = 1'b1;
    expect_out("ntf_start", 6'b000011);
    step(2);
    check_out();
    expect_out("ntf_f1", 6'b000011); frame(); check_out();
    expect_out("ntf_f2", 6'b000011); frame(); check_out();
    expect_out("ntf_f3", 6'b000001); frame(); check_out();

    // P2 notice restart after 2nd tick
    p2_connected = 1'b0;
    expect_out("ntf2_start", 6'b000011);
    step(2);
    check_out();
    frame();
    frame();
    p2_connected = 1'b1;
    expect_out("ntf2_reload", 6'b000011);
    step(2);
    check_out();
    expect_out("ntf2_f1", 6'b000011); frame(); check_out();
    expect_out("ntf2_f2", 6'b000011); frame(); check_out();
    expect_out("ntf2_f3", 6'b000001); frame(); check_out();

    // Game end, looser, blink pattern 1,1,0,0,1,1 then PLAY
    game_over = 1'b1;
    looser    = 1'b1;
    expect_out("res_entry", 6'b001100);
    step(2);
    check_out();
    expect_out("res_f1", 6'b001100); frame(); check_out();
    expect_out("res_f2", 6'b000100); frame(); check_out();
    expect_out("res_f3", 6'b000100); frame(); check_out();
    expect_out("res_f4", 6'b001100); frame(); check_out();
    expect_out("res_f5", 6'b001100); frame(); check_out();
    expect_out("res_exit_play", 6'b000101); frame(); check_out();

    // Game end with pause rising in the same cycle; exit to PAUSE
    game_over = 1'b0;
    step(2);
    game_over = 1'b1;
    looser    = 1'b0;
    pause     = 1'b1;
    expect_out("res_vs_pause", 6'b001000);
    step(2);
    check_out();
    frame(); frame(); frame(); frame();
    expect_out("resp_f5", 6'b001000); frame(); check_out();
    expect_out("res_exit_pause", 6'b110010); frame(); check_out();

    // P2 edge coinciding with a tick: load wins
    pause     = 1'b0;
    game_over = 1'b0;
    expect_out("back_to_play", 6'b000001);
    step(2);
    check_out();
    vsync = 1'b1;
    step(1);
    p2_connected = 1'b0;
    step(1);
    vsync = 1'b0;
    expect_out("coll_load", 6'b000011);
    step(18);
    check_out();
    expect_out("coll_f1", 6'b000011); frame(); check_out();
    expect_out("coll_f2", 6'b000011); frame(); check_out();
    expect_out("coll_f3", 6'b000001); frame(); check_out();

    // Reset during RESULT
    game_over = 1'b1;
    looser    = 1'b1;
    expect_out("mid_res_entry", 6'b001100);
    step(2);
    check_out();
    frame();
    rst          = 1'b1;
    game_over    = 1'b0;
    p2_connected = 1'b1;
    expect_out("mid_reset", 6'b000000);
    step(1);
    check_out();
    rst = 1'b0;
    expect_out("mid_release_p2", 6'b000011);
    step(1);
    check_out();

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
